// File: rtl/user_if_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | user_if_pkg : shared handshake-width constants for user IF       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package user_if_pkg;
   localparam int USER_PAYLOAD_BITS = 32;
   localparam int USER_PORT_ID_BITS = 3;
   localparam int USER_STAT_BITS    = 16;
endpackage
`default_nettype wire

// File: rtl/user_in_rr_merge_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter : round-robin arbiter, one-hot grant + index, pointer  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rr_arbiter #(
   parameter int NUM_REQ  = 5,
   parameter int IDX_BITS = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_REQ-1:0]  req,
   input  logic                advance,
   output logic [NUM_REQ-1:0]  grant,
   output logic [IDX_BITS-1:0] grant_idx,
   output logic                grant_vld
);

   logic [IDX_BITS-1:0] r_ptr;
   logic [IDX_BITS-1:0] w_hi_idx;
   logic [IDX_BITS-1:0] w_lo_idx;
   logic                w_hi_found;
   logic                w_lo_found;

   // Lowest requester at/after the pointer wins; otherwise wrap to lowest overall.
   always_comb begin
      w_hi_found = 1'b0;
      w_lo_found = 1'b0;
      w_hi_idx   = '0;
      w_lo_idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[k]) begin
            w_lo_found = 1'b1;
            w_lo_idx   = IDX_BITS'(k);
            if (k >= int'(r_ptr)) begin
               w_hi_found = 1'b1;
               w_hi_idx   = IDX_BITS'(k);
            end
         end
      end
      grant_vld = advance && (w_hi_found || w_lo_found);
      grant_idx = w_hi_found ? w_hi_idx : w_lo_idx;
      grant     = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (grant_vld) begin
         r_ptr <= (grant_idx == IDX_BITS'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/user_in_rr_merge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | user_in_rr_merge : N-port round-robin merge into one output reg   |
// | Option: USER_IN_RR_MERGE_STATS_EN adds per-port transfer counters |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module user_in_rr_merge
   import user_if_pkg::*;
#(
   parameter int NUM_IN_PORTS = 5,
   parameter int PAYLOAD_BITS = USER_PAYLOAD_BITS,
   parameter int PORT_ID_BITS = USER_PORT_ID_BITS
) (
   input  logic                                 clk_user,
   input  logic                                 reset_n,
   input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0] din,
   input  logic [NUM_IN_PORTS-1:0]              vld_in,
   output logic [NUM_IN_PORTS-1:0]              ack_out,
   output logic [PAYLOAD_BITS-1:0]              dout,
   output logic [PORT_ID_BITS-1:0]              dout_port,
   output logic                                 vld_out,
   input  logic                                 ack_in
`ifdef USER_IN_RR_MERGE_STATS_EN
   ,
   output logic [NUM_IN_PORTS*USER_STAT_BITS-1:0] port_xfer_cnt
`endif
);

   logic [PAYLOAD_BITS-1:0] r_hold [NUM_IN_PORTS];
   logic [NUM_IN_PORTS-1:0] r_full;
   logic [PAYLOAD_BITS-1:0] r_dout;
   logic [PORT_ID_BITS-1:0] r_dout_port;
   logic                    r_vld_out;

   logic [NUM_IN_PORTS-1:0] w_grant;
   logic [PORT_ID_BITS-1:0] w_grant_idx;
   logic                    w_grant_vld;
   logic                    w_load_out;
   logic [PAYLOAD_BITS-1:0] w_sel_data;

   assign w_load_out = !r_vld_out || ack_in;
   assign ack_out    = ~r_full | w_grant;
   assign dout       = r_dout;
   assign dout_port  = r_dout_port;
   assign vld_out    = r_vld_out;

   rr_arbiter #(
      .NUM_REQ  (NUM_IN_PORTS),
      .IDX_BITS (PORT_ID_BITS)
   ) u_arb (
      .clk       (clk_user),
      .rst_n     (reset_n),
      .req       (r_full),
      .advance   (w_load_out),
      .grant     (w_grant),
      .grant_idx (w_grant_idx),
      .grant_vld (w_grant_vld)
   );

   always_comb begin
      w_sel_data = '0;
      for (int k = 0; k < NUM_IN_PORTS; k++) begin
         if (w_grant[k]) begin
            w_sel_data = w_sel_data | r_hold[k];
         end
      end
   end

   // A new word may replace a word that is leaving this cycle; full stays set.
   always_ff @(posedge clk_user or negedge reset_n) begin
      if (!reset_n) begin
         r_full <= '0;
         for (int k = 0; k < NUM_IN_PORTS; k++) begin
            r_hold[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_IN_PORTS; k++) begin
            if (vld_in[k] && ack_out[k]) begin
               r_hold[k] <= din[k*PAYLOAD_BITS +: PAYLOAD_BITS];
               r_full[k] <= 1'b1;
            end else if (w_grant[k]) begin
               r_full[k] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk_user or negedge reset_n) begin
      if (!reset_n) begin
         r_vld_out   <= 1'b0;
         r_dout      <= '0;
         r_dout_port <= '0;
      end else if (w_load_out) begin
         r_vld_out <= w_grant_vld;
         if (w_grant_vld) begin
            r_dout      <= w_sel_data;
            r_dout_port <= w_grant_idx;
         end
      end
   end

`ifdef USER_IN_RR_MERGE_STATS_EN
   generate
      for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_stat
         logic [USER_STAT_BITS-1:0] r_cnt;
         always_ff @(posedge clk_user or negedge reset_n) begin
            if (!reset_n) begin
               r_cnt <= '0;
            end else if (r_vld_out && ack_in && (r_dout_port == PORT_ID_BITS'(i))) begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
         assign port_xfer_cnt[i*USER_STAT_BITS +: USER_STAT_BITS] = r_cnt;
      end
   endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_user_in_rr_merge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_user_in_rr_merge : directed + random bench with per-port       |
// | scoreboard queues. Rev 1.0                                        |
// +------------------------------------------------------------------+
module tb_user_in_rr_merge;
   localparam int NUM = 5;
   localparam int PB  = 32;
   localparam int PID = 3;

   logic              clk_user;
   logic              reset_n;
   logic [NUM*PB-1:0] din;
   logic [NUM-1:0]    vld_in;
   logic [NUM-1:0]    ack_out;
   logic [PB-1:0]     dout;
   logic [PID-1:0]    dout_port;
   logic              vld_out;
   logic              ack_in;
`ifdef USER_IN_RR_MERGE_STATS_EN
   logic [NUM*16-1:0] port_xfer_cnt;
`endif

   user_in_rr_merge #(
      .NUM_IN_PORTS (NUM),
      .PAYLOAD_BITS (PB),
      .PORT_ID_BITS (PID)
   ) dut (
      .clk_user  (clk_user),
      .reset_n   (reset_n),
      .din       (din),
      .vld_in    (vld_in),
      .ack_out   (ack_out),
      .dout      (dout),
      .dout_port (dout_port),
      .vld_out   (vld_out),
      .ack_in    (ack_in)
`ifdef USER_IN_RR_MERGE_STATS_EN
      ,
      .port_xfer_cnt (port_xfer_cnt)
`endif
   );

   initial clk_user = 1'b0;
   always #5 clk_user = ~clk_user;

   int          n_check = 0;
   int          n_pass  = 0;
   int          n_fail  = 0;
   int          n_out   = 0;
   int          seq [NUM];
   logic [31:0] base [NUM];
   logic [31:0] q [NUM][$];
   logic [15:0] exp_cnt [NUM];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_check++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_din();
      for (int i = 0; i < NUM; i++) din[i*PB +: PB] = base[i] + 32'(seq[i]);
   endtask

   task automatic clear_model();
      for (int i = 0; i < NUM; i++) begin
         q[i].delete();
         seq[i]     = 0;
         exp_cnt[i] = '0;
         base[i]    = 32'(i) << 24;
      end
      n_out = 0;
   endtask

   function automatic int q_total();
      int s = 0;
      for (int i = 0; i < NUM; i++) s += q[i].size();
      return s;
   endfunction

   // Observe handshakes just before the edge, then advance one clock.
   task automatic tick();
      int p;
      @(negedge clk_user);
      if (reset_n) begin
         for (int i = 0; i < NUM; i++) begin
            if (vld_in[i] && ack_out[i]) begin
               q[i].push_back(din[i*PB +: PB]);
               seq[i]++;
            end
         end
         if (vld_out && ack_in) begin
            n_out++;
            p = int'(dout_port);
            check("sb_port_range", 64'(p < NUM), 64'd1);
            if (p < NUM) begin
               exp_cnt[p] = exp_cnt[p] + 16'd1;
               check("sb_nonempty", 64'(q[p].size() != 0), 64'd1);
               if (q[p].size() != 0) check("sb_data", 64'(dout), 64'(q[p].pop_front()));
            end
         end
      end
      @(posedge clk_user);
      #1;
      drive_din();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      vld_in  = '0;
      ack_in  = 1'b0;
      clear_model();
      drive_din();
      repeat (2) @(posedge clk_user);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      logic [31:0] d0;
      logic [2:0]  p0;
      int          cyc;
      int          outs;

      reset_n = 1'b0;
      din     = '0;
      do_reset();

      // reset state
      check("rst_vld_out", 64'(vld_out), 64'd0);
      check("rst_dout", 64'(dout), 64'd0);
      check("rst_dout_port", 64'(dout_port), 64'd0);
      check("rst_ack_out", 64'(ack_out), 64'h1F);

      // single word on port 3, two-edge latency, one cycle valid
      base[3] = 32'hDEADBEEF;
      drive_din();
      vld_in = 5'b01000;
      ack_in = 1'b1;
      tick();
      vld_in = '0;
      check("single_not_yet", 64'(vld_out), 64'd0);
      tick();
      check("single_vld", 64'(vld_out), 64'd1);
      check("single_dout", 64'(dout), 64'hDEADBEEF);
      check("single_port", 64'(dout_port), 64'd3);
      tick();
      check("single_one_cycle", 64'(vld_out), 64'd0);

      // all ports streaming: strict rotation, no bubbles
      do_reset();
      vld_in = '1;
      ack_in = 1'b1;
      tick();
      for (int k = 0; k < 15; k++) begin
         tick();
         check("rr_vld", 64'(vld_out), 64'd1);
         check("rr_port", 64'(dout_port), 64'(k % NUM));
      end
      vld_in = '0;
      repeat (10) tick();
      check("rr_drained", 64'(q_total()), 64'd0);

      // backpressure freeze and lossless release
      do_reset();
      vld_in = '1;
      ack_in = 1'b0;
      repeat (2) tick();
      check("bp_ack_out", 64'(ack_out), 64'd0);
      check("bp_vld", 64'(vld_out), 64'd1);
      d0 = dout;
      p0 = dout_port;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("bp_frozen_dout", 64'(dout), 64'(d0));
         check("bp_frozen_port", 64'(dout_port), 64'(p0));
         check("bp_frozen_vld", 64'(vld_out), 64'd1);
         check("bp_frozen_ack", 64'(ack_out), 64'd0);
      end
      vld_in = '0;
      ack_in = 1'b1;
      repeat (12) tick();
      check("bp_words_out", 64'(n_out), 64'd6);
      check("bp_no_loss", 64'(q_total()), 64'd0);

      // two interleaved streams with random backpressure
      do_reset();
      base[2] = 32'd0;
      base[4] = 32'd1000;
      drive_din();
      cyc = 0;
      while ((n_out < 200) && (cyc < 3000)) begin
         vld_in = {seq[4] < 100, 1'b0, seq[2] < 100, 2'b00};
         ack_in = 1'($urandom_range(0, 1));
         tick();
         cyc++;
      end
      check("mix_words_out", 64'(n_out), 64'd200);
      check("mix_port2_in", 64'(seq[2]), 64'd100);
      check("mix_port4_in", 64'(seq[4]), 64'd100);
      check("mix_left", 64'(q_total()), 64'd0);

      // asynchronous reset mid-stream
      do_reset();
      vld_in = '1;
      ack_in = 1'b1;
      repeat (4) tick();
      check("ar_pre_vld", 64'(vld_out), 64'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("ar_vld", 64'(vld_out), 64'd0);
      check("ar_ack_out", 64'(ack_out), 64'h1F);
      check("ar_dout", 64'(dout), 64'd0);
      check("ar_port", 64'(dout_port), 64'd0);
      clear_model();
      vld_in = '0;
      tick();
      reset_n = 1'b1;
      base[1] = 32'h0BADF00D;
      drive_din();
      vld_in = 5'b00010;
      check("ar_post_ack", 64'(ack_out), 64'h1F);
      tick();
      vld_in = '0;
      tick();
      check("ar_post_vld", 64'(vld_out), 64'd1);
      check("ar_post_dout", 64'(dout), 64'h0BADF00D);
      check("ar_post_port", 64'(dout_port), 64'd1);
      tick();
      check("ar_post_done", 64'(vld_out), 64'd0);

`ifdef USER_IN_RR_MERGE_STATS_EN
      // counter wrap: 65537 transfers from port 0
      do_reset();
      vld_in = 5'b00001;
      ack_in = 1'b1;
      cyc = 0;
      while ((seq[0] < 65537) && (cyc < 70000)) begin
         tick();
         cyc++;
         if (seq[0] >= 65537) vld_in = '0;
      end
      vld_in = '0;
      outs = 0;
      repeat (5) tick();
      outs = n_out;
      check("st_words_out", 64'(outs), 64'd65537);
      check("st_cnt0", 64'(port_xfer_cnt[15:0]), 64'd1);
      for (int i = 0; i < NUM; i++)
         check("st_cnt_model", 64'(port_xfer_cnt[i*16 +: 16]), 64'(exp_cnt[i]));
`else
      outs = n_out;
      check("st_absent_outs", 64'(outs), 64'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_check);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/user_in_rr_merge.md
USER_IN_RR_MERGE -- requirements
Module: user_in_rr_merge

Interface
REQ-001 SHALL have parameter NUM_IN_PORTS, default 5: number of leaf-interface output ports merged (range 2..16).
REQ-002 SHALL have parameter PAYLOAD_BITS, default 32: data word width.
REQ-003 SHALL have parameter PORT_ID_BITS, default 3: width of the source-port tag, at least clog2(NUM_IN_PORTS).
REQ-004 SHALL have the port clk_user, input, 1: the only clock; one clock, all logic rising-edge.
REQ-005 SHALL have the port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have the port din, input, NUM_IN_PORTS*PAYLOAD_BITS: concatenated words from the leaf interface; port i occupies slice i.
REQ-007 SHALL have the port vld_in, input, NUM_IN_PORTS: per-port valid.
REQ-008 SHALL have the port ack_out, output, NUM_IN_PORTS: per-port accept back to the leaf interface.
REQ-009 SHALL have the port dout, output, PAYLOAD_BITS: merged word to the user kernel.
REQ-010 SHALL have the port dout_port, output, PORT_ID_BITS: source-port index of dout.
REQ-011 SHALL have the port vld_out, output, 1: dout/dout_port valid.
REQ-012 SHALL have the port ack_in, input, 1: the user kernel accepts.

Function
REQ-013 SHALL treat a transfer as occurring on any edge where vld and ack are both high (input side per port, output side on vld_out/ack_in).
REQ-014 SHALL hold one holding register (data + full flag) per input port.
REQ-015 SHALL drive ack_out[i] = !full[i] || (grant to port i this cycle); the ack_out depends combinationally on ack_in and on the arbiter only.
REQ-016 SHALL have a single output register stage; it loads when it is empty, or when a transfer with ack_in occurs in that cycle.
REQ-017 SHALL arbitrate round-robin among full holding registers, and SHALL grant only when the output stage loads.
REQ-018 SHALL set the round-robin pointer to 0 after reset; after a grant to port k, highest priority becomes (k+1) mod NUM_IN_PORTS.
REQ-019 SHALL have a latency of 2 cycles from input transfer to vld_out when idle: holding register loads at edge N+1, output register loads at edge N+2.
REQ-020 SHALL hold dout, dout_port and vld_out stable while vld_out=1 and ack_in=0.
REQ-021 SHALL handle a simultaneous grant of port i and a new input transfer on port i in the same cycle: the old word goes to output and the new word replaces it, with full[i] staying 1.
REQ-022 SHALL allow a holding-register load for port i only when vld_in[i]=1; an empty port is never granted.
REQ-023 SHALL sustain throughput of 1 word/cycle with ack_in held at 1; no bubbles when any port has data.
REQ-024 SHALL guarantee fairness: with all ports continuously valid and ack_in=1, each port is granted exactly once in every NUM_IN_PORTS consecutive grants.
REQ-025 SHALL preserve per-port word order; words are never dropped or duplicated.

Reset
REQ-026 SHALL, on reset_n=0 and immediately (asynchronous): clear all full flags, set vld_out=0, dout=0, dout_port=0, RR pointer=0.
REQ-027 SHALL drive ack_out = all ones while in reset, because all slots are empty; the upstream is itself held in reset by system convention.
REQ-028 SHALL discard any in-flight words if reset is asserted mid-operation; there is no recovery of words.
REQ-029 SHALL synchronise reset_n deassertion externally; the block uses it directly.

Configuration
REQ-030 SHALL, when the macro USER_IN_RR_MERGE_STATS_EN is defined, add an output port_xfer_cnt of width NUM_IN_PORTS*16: per-port 16-bit counters of output transfers that wrap at 0xFFFF->0 and reset to 0.
REQ-031 SHALL, when the macro USER_IN_RR_MERGE_STATS_EN is undefined, have neither the port nor the counters.

Structure
REQ-032 SHALL place the handshake-width constants (PAYLOAD_BITS default 32, port-tag width) in a shared package user_if_pkg; the parameters above default from it.
REQ-033 SHALL implement the arbiter as one sub-module rr_arbiter (request vector, advance strobe -> one-hot grant + index, owns the pointer).

Verification
REQ-034 SHALL be verified with: single word 0xDEADBEEF on port 3 with ack_in=1 -> vld_out at edge+2, dout=0xDEADBEEF, dout_port=3, one cycle.
REQ-035 SHALL be verified with: all 5 ports valid continuously with ack_in=1 -> dout_port sequence 0,1,2,3,4,0,... with vld_out never dropping.
REQ-036 SHALL be verified with: ack_in=0 for 10 cycles with all ports valid -> output frozen, ack_out=0 on all 5 ports after 2 cycles, no data loss when ack_in returns.
REQ-037 SHALL be verified with: port 2 streaming 0..99 while port 4 streams 1000..1099, random ack_in -> per-port order preserved, 200 words out total.
REQ-038 SHALL be verified with: reset_n pulsed low mid-stream with vld_out=1 -> vld_out=0 that same cycle asynchronously, ack_out=0x1F, first word after release accepted normally.
REQ-039 SHALL be verified with: USER_IN_RR_MERGE_STATS_EN defined, 65537 words from port 0 -> port_xfer_cnt[0]=1.
